axi4_sram_responder: RTL and testbench
======================================

Name: axi4_sram_responder

Overview:
- AXI4 slave memory model; the responder end of the data-cache AXI master port.
- Backs LSU/dcache traffic in simulation and FPGA builds with single-port synchronous SRAM.
- Serves one transaction at a time and supports INCR/FIXED bursts, byte strobes and range decode errors.

Parameters:
- ADDR_BASE, 32'h8000_0000, first byte address decoded by this slave.
- MEM_BYTES, 4096, memory size in bytes; power of two, at least 4.
- ID_W, 4, AXI ID width.
- READ_LAT, 1, idle cycles between AR handshake and first rvalid (0..15).

Ports:
- clock  in  1  clock.
- reset  in  1  reset: asynchronous, active-high.
- awid/awaddr/awlen/awsize/awburst  in  ID_W/32/8/3/2  write address channel.
- awvalid in 1; awready out 1  write address handshake.
- wdata/wstrb/wlast  in  32/4/1  write data channel.
- wvalid in 1; wready out 1  write data handshake.
- bid/bresp  out  ID_W/2  write response.
- bvalid out 1; bready in 1  write response handshake.
- arid/araddr/arlen/arsize/arburst  in  ID_W/32/8/3/2  read address channel.
- arvalid in 1; arready out 1  read address handshake.
- rid/rdata/rresp/rlast  out  ID_W/32/2/1  read data channel.
- rvalid out 1; rready in 1  read data handshake.

Behaviour:
- States: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- Reset values: all ready/valid outputs 0; rdata, rid, bid, rresp, bresp 0; rlast 0. Reset forces IDLE from any state and abandons any burst. SRAM contents are not reset.
- IDLE:
  - arready = arvalid & (~awvalid | ~wr_prio).
  - awready = awvalid & (~arvalid | wr_prio).
  - wr_prio resets to 0 (reads win first). It toggles after every simultaneous AR/AW conflict, giving round-robin arbitration.
- Read path:
  - AR handshake latches id, addr, len, size, burst and beat counter = 0.
  - Go to RD_WAIT for READ_LAT cycles. If READ_LAT=0, go straight to RD_DATA with rvalid on the next cycle.
  - RD_DATA: rvalid=1; rdata = word at addr[31:2]; rlast = (count==len).
  - Outputs hold stable while rvalid & ~rready.
  - On each rready beat: INCR adds 1<<size to addr; FIXED keeps addr.
  - Last beat accepted returns to IDLE. One SRAM read is issued per beat, so the next beat's rvalid may drop for one cycle.
- Write path:
  - AW handshake latches fields, then WR_DATA with wready=1.
  - Each W beat writes the bytes whose wstrb bit is set, at word addr[31:2]; the address advances as for reads.
  - Beat (count==len) or wlast ends the burst, whichever comes first. A wlast/count mismatch sets bresp=SLVERR; every beat still writes normally.
  - WR_RESP: bvalid=1 with bid latched. Hold until bready, then IDLE.
- Errors:
  - Address outside [ADDR_BASE, ADDR_BASE+MEM_BYTES) on any beat gives DECERR (2'b11). Reads of such beats return rdata 0; writes are suppressed.
  - awburst/arburst = WRAP or 2'b11 gives SLVERR (2'b10) for the whole burst; data is not accessed.
  - Read errors are reported per beat in rresp. bresp carries the worst error seen in the burst.
- Address wrap-around inside memory is not performed; offsets use addr-ADDR_BASE, truncated to log2(MEM_BYTES) bits only after the range check.
- Narrow transfers: size<2 uses the byte lanes selected by addr[1:0]. The slave does not remask wstrb; it trusts the master's strobe.
- Never more than one outstanding transaction. arready and awready are 0 outside IDLE.

Test Plan:
- Single write then read: AW addr 0x8000_0010, len 0, wdata 0xDEADBEEF, wstrb 4'hF → bresp 0. AR same addr → rdata 0xDEADBEEF, rlast=1, rvalid exactly READ_LAT+1 cycles after the AR handshake.
- Byte strobe: write 0x11223344, then write wdata 0xAA000000 with wstrb 4'b1000 → readback 0xAA223344.
- INCR burst len 3 at 0x8000_0100 writing 1,2,3,4, then read back with rready toggling every other cycle → four beats 1..4 with rdata held during stalls; rlast only on beat 4.
- Simultaneous AR and AW in IDLE, three times → order read, write, read (wr_prio toggles); responses carry the correct rid/bid.
- Out of range: AR 0x7FFF_FFFC → rresp 2'b11, rdata 0. AW 0x8000_1000 → bresp 2'b11 and memory unchanged. WRAP burst → SLVERR.
- Reset asserted mid read burst (beat 2 of 4) → rvalid drops asynchronously; after release arready rises in IDLE and the next read succeeds.

Source files
------------

// File: rtl/axi4_sram_responder_if.sv
// rtl/axi4_sram_responder_if.sv - AXI4 five-channel bundle between a master and the SRAM responder
//
// Purpose: groups the AW/W/B/AR/R channels of one AXI4 link (32-bit data,
//          ID_W-bit IDs, no cache/prot/qos/user sidebands).
// Ports (modports):
//   master - drives aw*/w*/ar* payload+valid and bready/rready; samples the rest.
//   slave  - drives awready/wready/arready and the B and R channels.
interface axi4_sram_responder_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_sram_responder.sv
// rtl/axi4_sram_responder.sv - AXI4 slave memory model backed by a single-port synchronous SRAM
//
// Purpose: serves one AXI4 transaction at a time (INCR/FIXED bursts, byte
//          strobes, DECERR outside [ADDR_BASE, ADDR_BASE+MEM_BYTES), SLVERR
//          for WRAP/reserved bursts and for wlast/len disagreement).
// Ports:
//   clock - clock.
//   reset - asynchronous, active-high; returns to IDLE and abandons any burst.
//   bus   - AXI4 slave modport (AW, W, B, AR, R channels).
module axi4_sram_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          MEM_BYTES = 4096,
  parameter int          ID_W      = 4,
  parameter int          READ_LAT  = 1
) (
  input logic                    clock,
  input logic                    reset,
  axi4_sram_responder_if.slave   bus
);
  localparam int OFF_W = $clog2(MEM_BYTES);
  localparam int IDX_W = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam int WORDS = MEM_BYTES / 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;
  state_t state, state_nxt;

  logic [31:0]     mem [WORDS];
  logic            wr_prio;
  logic [31:0]     addr_q;
  logic [7:0]      len_q, cnt_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [3:0]      wait_q;
  logic [1:0]      werr_q;
  logic            rvalid_q, rlast_q;
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q, bresp_q;
  logic [ID_W-1:0] rid_q, bid_q;

  logic            ar_hs, aw_hs, fetch, r_beat, w_beat, w_end;
  logic [31:0]     f_addr;
  logic [1:0]      f_burst, f_resp, w_resp, w_mism, w_fin;
  logic [7:0]      f_cnt, f_len;

  // The range check is done on the full 33-bit difference so addresses below
  // ADDR_BASE come out huge; only in-range offsets are ever truncated.
  function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic [1:0] burst);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, ADDR_BASE};
    if (burst != BURST_FIXED && burst != BURST_INCR) return RESP_SLVERR;
    else if (off >= 33'(MEM_BYTES))                  return RESP_DECERR;
    else                                             return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, ADDR_BASE};
    return off[IDX_W+1:2];
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [2:0] size);
    return (burst == BURST_INCR) ? a + (32'd1 << size) : a;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // With READ_LAT=0 the first SRAM read is launched on the AR handshake edge
  // itself, so the fetch operands bypass the (not yet loaded) registers.
  assign f_addr  = ar_hs ? bus.araddr  : addr_q;
  assign f_burst = ar_hs ? bus.arburst : burst_q;
  assign f_cnt   = ar_hs ? 8'd0        : cnt_q;
  assign f_len   = ar_hs ? bus.arlen   : len_q;
  assign f_resp  = beat_resp(f_addr, f_burst);

  assign w_resp  = beat_resp(addr_q, burst_q);
  assign w_mism  = ((cnt_q == len_q) != bus.wlast) ? RESP_SLVERR : RESP_OKAY;
  assign w_fin   = worst(werr_q, worst(w_resp, w_mism));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.arready = 1'b0;
    bus.awready = 1'b0;
    ar_hs       = 1'b0;
    aw_hs       = 1'b0;
    fetch       = 1'b0;
    r_beat      = 1'b0;
    w_beat      = 1'b0;
    w_end       = 1'b0;
    case (state)
      IDLE: begin
        bus.arready = ~reset & bus.arvalid & (~bus.awvalid | ~wr_prio);
        bus.awready = ~reset & bus.awvalid & (~bus.arvalid | wr_prio);
        ar_hs       = bus.arready;
        aw_hs       = bus.awready;
        if (ar_hs) begin
          if (READ_LAT == 0) begin
            fetch     = 1'b1;
            state_nxt = RD_DATA;
          end else begin
            state_nxt = RD_WAIT;
          end
        end else if (aw_hs) begin
          state_nxt = WR_DATA;
        end
      end
      RD_WAIT: begin
        if (wait_q == 4'(READ_LAT - 1)) begin
          fetch     = 1'b1;
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        // rvalid low here means the previous beat was just taken: issue the
        // next SRAM read, which costs one bubble cycle per beat.
        if (!rvalid_q) begin
          fetch = 1'b1;
        end else if (bus.rready) begin
          r_beat = 1'b1;
          if (rlast_q) state_nxt = IDLE;
        end
      end
      WR_DATA: begin
        if (bus.wvalid) begin
          w_beat = 1'b1;
          w_end  = (cnt_q == len_q) | bus.wlast;
          if (w_end) state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_prio  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      wait_q   <= '0;
      werr_q   <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      bresp_q  <= RESP_OKAY;
      rid_q    <= '0;
      bid_q    <= '0;
    end else begin
      if (state == IDLE && bus.arvalid && bus.awvalid) wr_prio <= ~wr_prio;
      wait_q <= (state == RD_WAIT) ? wait_q + 4'd1 : 4'd0;

      if (ar_hs) begin
        addr_q  <= bus.araddr;
        len_q   <= bus.arlen;
        size_q  <= bus.arsize;
        burst_q <= bus.arburst;
        cnt_q   <= '0;
        rid_q   <= bus.arid;
      end else if (aw_hs) begin
        addr_q  <= bus.awaddr;
        len_q   <= bus.awlen;
        size_q  <= bus.awsize;
        burst_q <= bus.awburst;
        cnt_q   <= '0;
        bid_q   <= bus.awid;
        werr_q  <= RESP_OKAY;
      end

      if (fetch) begin
        rvalid_q <= 1'b1;
        rresp_q  <= f_resp;
        rlast_q  <= (f_cnt == f_len);
        rdata_q  <= (f_resp == RESP_OKAY) ? mem[word_idx(f_addr)] : 32'd0;
      end else if (r_beat) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
        addr_q   <= next_addr(addr_q, burst_q, size_q);
        cnt_q    <= cnt_q + 8'd1;
      end

      if (w_beat) begin
        addr_q <= next_addr(addr_q, burst_q, size_q);
        cnt_q  <= cnt_q + 8'd1;
        werr_q <= w_fin;
        if (w_end) bresp_q <= w_fin;
      end
    end
  end

  // SRAM array: contents survive reset. Strobes are trusted as given.
  always_ff @(posedge clock) begin
    if (w_beat && w_resp == RESP_OKAY) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[word_idx(addr_q)][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.wready = (state == WR_DATA);
  assign bus.bvalid = (state == WR_RESP);
  assign bus.bid    = bid_q;
  assign bus.bresp  = bresp_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;
  assign bus.rlast  = rlast_q;
  assign bus.rid    = rid_q;
endmodule

// File: tb/tb_axi4_sram_responder.sv
// tb/tb_axi4_sram_responder.sv - scoreboard bench for axi4_sram_responder
module tb_axi4_sram_responder;
  localparam int ID_W     = 4;
  localparam int READ_LAT = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  axi4_sram_responder_if #(.ID_W(ID_W)) bus ();

  axi4_sram_responder #(
    .ADDR_BASE(32'h8000_0000), .MEM_BYTES(4096), .ID_W(ID_W), .READ_LAT(READ_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            last;
  } rexp_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [7:0]  order_q[$];
  logic [31:0] wbuf[16];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          r_beats = 0;
  int          rr_mode = 0;  // 0: rready high, 1: two-high/two-low pattern, 2: rready low
  int          cyc = 0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    cyc++;
    case (rr_mode)
      1:       bus.rready = cyc[1];
      2:       bus.rready = 1'b0;
      default: bus.rready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted R/B beat and checks that a
  // stalled R beat keeps its payload.
  initial forever begin
    rexp_t re;
    bexp_t be;
    @(negedge clock);
    if (!reset) begin
      if (bus.rvalid) begin
        if (hold_valid) begin
          check("r_hold_data", bus.rdata, hold_data);
          check("r_hold_last", 32'(bus.rlast), 32'(hold_last));
        end
        if (bus.rready) begin
          hold_valid = 1'b0;
          r_beats++;
          if (rq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL r_unexpected: got rdata %h expected no beat", bus.rdata);
          end else begin
            re = rq.pop_front();
            check("rid",   32'(bus.rid),   32'(re.id));
            check("rdata", bus.rdata,      re.data);
            check("rresp", 32'(bus.rresp), 32'(re.resp));
            check("rlast", 32'(bus.rlast), 32'(re.last));
          end
        end else begin
          hold_valid = 1'b1;
          hold_data  = bus.rdata;
          hold_last  = bus.rlast;
        end
      end else begin
        hold_valid = 1'b0;
      end
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected: got bresp %b expected no response", bus.bresp);
        end else begin
          be = bq.pop_front();
          check("bid",   32'(bus.bid),   32'(be.id));
          check("bresp", 32'(bus.bresp), 32'(be.resp));
        end
      end
    end
  end

  task automatic rd_addr(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int t;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd2;
    bus.arburst = burst; bus.arvalid = 1'b1;
    t = 0;
    do begin @(negedge clock); t++; end while (!bus.arready && t < 200);
    if (!bus.arready) begin
      n_cmp++; n_bad++;
      $display("FAIL ar_timeout: got arready 0 expected 1");
    end
    @(posedge clock); #1;
    bus.arvalid = 1'b0;
    order_q.push_back("R");
  endtask

  task automatic wr(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input int nbeats, input int wlast_idx,
                    input logic [3:0] strb);
    int t;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd2;
    bus.awburst = burst; bus.awvalid = 1'b1;
    t = 0;
    do begin @(negedge clock); t++; end while (!bus.awready && t < 200);
    if (!bus.awready) begin
      n_cmp++; n_bad++;
      $display("FAIL aw_timeout: got awready 0 expected 1");
    end
    @(posedge clock); #1;
    bus.awvalid = 1'b0;
    order_q.push_back("W");
    for (int i = 0; i < nbeats; i++) begin
      bus.wdata = wbuf[i]; bus.wstrb = strb; bus.wlast = (i == wlast_idx); bus.wvalid = 1'b1;
      t = 0;
      do begin @(negedge clock); t++; end while (!bus.wready && t < 200);
      if (!bus.wready) begin
        n_cmp++; n_bad++;
        $display("FAIL w_timeout: got wready 0 expected 1");
      end
      @(posedge clock); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 400) begin @(negedge clock); t++; end
    if (rq.size() != 0 || bq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d r / %0d b pending expected 0", rq.size(), bq.size());
      rq.delete(); bq.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic push_r(input logic [ID_W-1:0] id, input logic [31:0] d, input logic [1:0] resp,
                        input logic last);
    rexp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    rq.push_back(e);
  endtask

  task automatic push_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
    bexp_t e;
    e.id = id; e.resp = resp;
    bq.push_back(e);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    #1 reset = 1'b1;
    bus.arvalid = 1'b1; bus.awvalid = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_arready", 32'(bus.arready), 0);
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_wready",  32'(bus.wready),  0);
    check("rst_bvalid",  32'(bus.bvalid),  0);
    check("rst_rvalid",  32'(bus.rvalid),  0);
    check("rst_rdata",   bus.rdata,        0);
    check("rst_rid",     32'(bus.rid),     0);
    check("rst_bid",     32'(bus.bid),     0);
    check("rst_rresp",   32'(bus.rresp),   0);
    check("rst_bresp",   32'(bus.bresp),   0);
    check("rst_rlast",   32'(bus.rlast),   0);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    // single write then read, with first-beat latency
    wbuf[0] = 32'hDEAD_BEEF;
    push_b(4'd1, 2'b00);
    wr(4'd1, 32'h8000_0010, 8'd0, 2'b01, 1, 0, 4'hF);
    drain();
    push_r(4'd2, 32'hDEAD_BEEF, 2'b00, 1'b1);
    rd_addr(4'd2, 32'h8000_0010, 8'd0, 2'b01);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.rvalid && n < 50);
    check("rd_latency", n, READ_LAT + 1);
    drain();

    // byte strobe merge
    wbuf[0] = 32'h1122_3344;
    push_b(4'd3, 2'b00);
    wr(4'd3, 32'h8000_0020, 8'd0, 2'b01, 1, 0, 4'hF);
    wbuf[0] = 32'hAA00_0000;
    push_b(4'd3, 2'b00);
    wr(4'd3, 32'h8000_0020, 8'd0, 2'b01, 1, 0, 4'b1000);
    push_r(4'd4, 32'hAA22_3344, 2'b00, 1'b1);
    rd_addr(4'd4, 32'h8000_0020, 8'd0, 2'b01);
    drain();

    // INCR burst of 4, read back with stalling rready
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    push_b(4'd5, 2'b00);
    wr(4'd5, 32'h8000_0100, 8'd3, 2'b01, 4, 3, 4'hF);
    drain();
    rr_mode = 1;
    for (int i = 0; i < 4; i++) push_r(4'd6, 32'(i + 1), 2'b00, i == 3);
    rd_addr(4'd6, 32'h8000_0100, 8'd3, 2'b01);
    drain();
    rr_mode = 0;

    // FIXED read burst stays on one word
    push_r(4'd7, 32'd2, 2'b00, 1'b0);
    push_r(4'd7, 32'd2, 2'b00, 1'b1);
    rd_addr(4'd7, 32'h8000_0104, 8'd1, 2'b00);
    drain();

    // simultaneous AR/AW: round-robin read, write, read
    for (int r = 0; r < 3; r++) begin
      order_q.delete();
      wbuf[0] = 32'h1000 + 32'(r);
      push_b(4'(r + 1), 2'b00);
      push_r(4'(r + 8), 32'(r + 1), 2'b00, 1'b1);
      fork
        rd_addr(4'(r + 8), 32'h8000_0100 + 32'(4 * r), 8'd0, 2'b01);
        wr(4'(r + 1), 32'h8000_0200 + 32'(4 * r), 8'd0, 2'b01, 1, 0, 4'hF);
      join
      drain();
      check("arb_winner", 32'(order_q[0]), (r == 1) ? 32'("W") : 32'("R"));
    end
    push_r(4'd9, 32'h1001, 2'b00, 1'b1);
    rd_addr(4'd9, 32'h8000_0204, 8'd0, 2'b01);
    drain();

    // decode errors and burst-type errors
    push_r(4'd10, 32'd0, 2'b11, 1'b1);
    rd_addr(4'd10, 32'h7FFF_FFFC, 8'd0, 2'b01);
    drain();
    wbuf[0] = 32'hCAFE_F00D;
    push_b(4'd11, 2'b00);
    wr(4'd11, 32'h8000_0000, 8'd0, 2'b01, 1, 0, 4'hF);
    wbuf[0] = 32'h1234_5678;
    push_b(4'd12, 2'b11);
    wr(4'd12, 32'h8000_1000, 8'd0, 2'b01, 1, 0, 4'hF);
    push_r(4'd13, 32'hCAFE_F00D, 2'b00, 1'b1);
    rd_addr(4'd13, 32'h8000_0000, 8'd0, 2'b01);
    drain();
    wbuf[0] = 32'h5; wbuf[1] = 32'h6;
    push_b(4'd14, 2'b10);
    wr(4'd14, 32'h8000_0300, 8'd1, 2'b10, 2, 1, 4'hF);
    push_r(4'd15, 32'd0, 2'b10, 1'b0);
    push_r(4'd15, 32'd0, 2'b10, 1'b1);
    rd_addr(4'd15, 32'h8000_0100, 8'd1, 2'b10);
    drain();

    // early wlast: burst ends, SLVERR, beat still written
    wbuf[0] = 32'h55;
    push_b(4'd1, 2'b10);
    wr(4'd1, 32'h8000_0400, 8'd1, 2'b01, 1, 0, 4'hF);
    push_r(4'd2, 32'h55, 2'b00, 1'b1);
    rd_addr(4'd2, 32'h8000_0400, 8'd0, 2'b01);
    drain();

    // reset in the middle of a read burst
    for (int i = 0; i < 4; i++) push_r(4'd3, 32'(i + 1), 2'b00, i == 3);
    base = r_beats;
    rd_addr(4'd3, 32'h8000_0100, 8'd3, 2'b01);
    n = 0;
    while (r_beats < base + 1 && n < 100) begin @(negedge clock); n++; end
    rr_mode = 2;
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.rvalid && n < 20);
    check("beat2_pending", 32'(bus.rvalid), 1);
    #2 reset = 1'b1;
    #1 check("rvalid_async_drop", 32'(bus.rvalid), 0);
    rq.delete();
    hold_valid = 1'b0;
    rr_mode = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    push_r(4'd5, 32'd2, 2'b00, 1'b1);
    bus.arid = 4'd5; bus.araddr = 32'h8000_0104; bus.arlen = 8'd0; bus.arsize = 3'd2;
    bus.arburst = 2'b01; bus.arvalid = 1'b1;
    @(negedge clock);
    check("arready_after_reset", 32'(bus.arready), 1);
    @(posedge clock); #1;
    bus.arvalid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
